// File: rtl/alu_result_sink_pkg.sv
// Shared definitions for the ALU result sink: default sizes, flag bit
// positions and FSM state encodings.
package alu_result_sink_pkg;

  localparam int ALU_SINK_WIDTH = 8;
  localparam int ALU_SINK_DEPTH = 4;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } sink_state_e;

endpackage

// File: rtl/alu_result_sink_if.sv
// Bus between the ALU/output stage (master) and the result sink (slave).
interface alu_result_sink_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Y;
  logic             flush;
  logic [WIDTH-1:0] acc;
  logic [3:0]       flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport slave (
    input  in_valid, A, B, Y, flush, out_ready,
    output in_ready, acc, flags, out_valid, out_data, count
  );

  modport master (
    output in_valid, A, B, Y, flush, out_ready,
    input  in_ready, acc, flags, out_valid, out_data, count
  );

endinterface

// File: rtl/alu_sink_fifo.sv
// DEPTH x WIDTH result FIFO with synchronous clear. Pointers wrap naturally
// because DEPTH is a power of two; head reads as zero while empty.
module alu_sink_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next pointer/count/storage; clear wins over any push or pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_result_sink.sv
// ALU result sink: captures each accepted result into ACC, derives
// {C,V,N,Z} status and queues results for the output stage.
// Build option: define ALU_SINK_FLAGS_EN to register status flags;
// without it the flags output is constant zero.
//
// state    | meaning
// ST_RUN   | accepting results and serving the FIFO
// ST_FLUSH | ACC, flags and FIFO cleared; no traffic in either direction
module alu_result_sink
  import alu_result_sink_pkg::*;
#(
  parameter int WIDTH = ALU_SINK_WIDTH,
  parameter int DEPTH = ALU_SINK_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_sink_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  sink_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             push, pop, clear;
  logic             in_ready, out_valid;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;

  // Handshake and flush sequencing; flush overrides push/pop in that cycle.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        in_ready  = !fifo_full;
        out_valid = !fifo_empty;
        if (bus.flush) begin
          state_d = ST_FLUSH;
          clear   = 1'b1;
        end else begin
          push = bus.in_valid && in_ready;
          pop  = out_valid && bus.out_ready;
        end
      end
      ST_FLUSH: begin
        clear   = 1'b1;
        state_d = bus.flush ? ST_FLUSH : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Accumulator follows the last accepted result.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (push) begin
      acc_d = bus.Y;
    end
  end

  // FSM and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

`ifdef ALU_SINK_FLAGS_EN
  logic [WIDTH:0] sum;
  logic [3:0]     flags_new;
  logic [3:0]     flags_q, flags_d;

  // Status of the presented result; carry comes from a widened A+B.
  always_comb begin
    sum               = {1'b0, bus.A} + {1'b0, bus.B};
    flags_new         = '0;
    flags_new[FLAG_C] = sum[WIDTH];
    flags_new[FLAG_V] = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                        (bus.Y[WIDTH-1] != bus.A[WIDTH-1]);
    flags_new[FLAG_N] = bus.Y[WIDTH-1];
    flags_new[FLAG_Z] = (bus.Y == '0);
    flags_d           = flags_q;
    if (clear) begin
      flags_d = '0;
    end else if (push) begin
      flags_d = flags_new;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.flags = flags_q;
`else
  logic unused_operands;
  assign unused_operands = ^{bus.A, bus.B};
  assign bus.flags       = 4'b0000;
`endif

  alu_sink_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (bus.Y),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = fifo_dout;
  assign bus.count     = fifo_count;
  assign bus.acc       = acc_q;

endmodule
